slot_reels: RTL and testbench
=============================

Name: slot_reels

Overview:
- Reel engine that sits directly upstream of the balance/bank stage and drives its four 4-bit symbol inputs.
- A rising edge on the spin button starts a spin. All four reels roll from a free-running LFSR, then lock left to right.
- When the last reel locks, the block issues a one-cycle result_valid pulse and a jackpot flag (all four symbols equal).
- Downstream consumers qualify payouts with result_valid.

Parameters:
- SEED, 16'hACE1: LFSR reset value. Must be nonzero.
- TICK_DIV, 2_500_000: clock cycles per reel-roll tick. Must be >= 2.
- SPIN_TICKS, 40: tick index at which reel1 locks.
- STAGGER_TICKS, 10: ticks between successive reel locks. Must be >= 1.
- NUM_SYMBOLS, 10: symbols per reel. Legal range 8..16.

Ports:
- clk  in  1  system clock; all flops on posedge.
- rst  in  1  asynchronous, active-low reset.
- spin  in  1  debounced spin button, synchronous to clk, level.
- randNum1  out  4  reel 1 symbol.
- randNum2  out  4  reel 2 symbol.
- randNum3  out  4  reel 3 symbol.
- randNum4  out  4  reel 4 symbol.
- spinning  out  1  high in SPIN state.
- result_valid  out  1  one-cycle pulse when all reels have locked.
- jackpot  out  1  registered all-equal flag; held until the next spin starts.

Behaviour:
- Reset (rst=0, async), applies at any time including mid-spin:
  - state=IDLE, LFSR=SEED, tick divider=0, tick count=0, all locks cleared.
  - randNum1..4 = 0,1,2,3 (deliberately unequal, so no downstream match at reset).
  - spinning=0, result_valid=0, jackpot=0, spin edge register=0.
- LFSR: 16-bit Galois, taps 16'hB400.
  - Advances every clock in every state, so human timing adds entropy.
  - Never reaches 0.
- Symbol mapping: reel k (k=1..4) uses nibble lfsr[4k-1:4k-4].
  - sym = nibble >= NUM_SYMBOLS ? nibble - NUM_SYMBOLS : nibble.
  - Result is always < NUM_SYMBOLS.
- Spin edge: spin_d registers spin; start = spin & ~spin_d.
- States: IDLE, SPIN, DONE.
- IDLE:
  - Outputs hold their last values.
  - start moves to SPIN and clears the divider, tick count, locks, and jackpot. Call this the entry edge.
  - spin level held high does not retrigger.
- SPIN:
  - spinning=1. Divider counts 0..TICK_DIV-1.
  - The edge where divider==TICK_DIV-1 is a tick: divider returns to 0 and tick count increments.
  - Tick j lands exactly j*TICK_DIV edges after the entry edge.
  - On each tick, every unlocked reel loads its mapped symbol from the current LFSR value. Locked reels hold.
  - Lock schedule: reel k locks on tick SPIN_TICKS+(k-1)*STAGGER_TICKS. The reel takes that tick's update, then holds.
  - On reel4's lock tick, state moves to DONE. jackpot is registered on the same edge from the post-update symbols.
  - start pulses during SPIN are ignored.
- DONE:
  - Lasts exactly one cycle: result_valid=1, spinning=0, then unconditionally IDLE.
  - A start in DONE is ignored; the user must release and re-press.
- Latency:
  - result_valid is high in the single cycle after edge (SPIN_TICKS+3*STAGGER_TICKS)*TICK_DIV counted from the entry edge.
  - Start to SPIN adds 1 cycle after the spin rise (edge detect is registered).
- Symbol outputs stay stable from reel4 lock until the next SPIN tick. jackpot is valid whenever result_valid=1.
- Counter widths are $clog2 of their maximum values. No wrap is possible within a spin.

Decomposition:
- Package slot_pkg holds:
  - state enum {IDLE, SPIN, DONE};
  - LFSR_TAPS=16'hB400;
  - the reset symbol constants 0,1,2,3;
  - the symbol-mapping function.
- One sub-module, slot_lfsr16: enable-free, async active-low reset to SEED, 16-bit state output.

Test Plan:
- Use TICK_DIV=4, SPIN_TICKS=3, STAGGER_TICKS=2 throughout.
- Reset: assert rst=0 mid-operation -> randNum1..4=0,1,2,3; spinning=0; result_valid=0; jackpot=0; LFSR=16'hACE1. State returns to IDLE.
- Basic spin: spin 0->1 -> spinning rises on the next edge. result_valid pulses exactly once, 36 edges after entry.
- Lock order: reel1 stops changing after tick 3, reel2 after tick 5, reel3 after tick 7, reel4 after tick 9. Values must match a reference LFSR model at those ticks.
- Retrigger/hold: spin held high 100 cycles, or re-pulsed during SPIN or DONE -> exactly one spin and one result_valid. A fresh rise in IDLE starts a new spin and clears jackpot.
- Reset mid-spin: rst=0 at tick 5 -> immediate IDLE with reset outputs; no result_valid.
- Mapping/jackpot: sweep spins with scoreboard -> all symbols < 10. jackpot matches the all-equal check on the locked symbols. Run until the model predicts a jackpot; jackpot=1 with result_valid.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot reel engine: FSM states, LFSR taps,
// reset symbols and the nibble-to-symbol fold.
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Element k is reel k+1; unequal so nothing downstream sees a match out of reset.
    localparam logic [3:0][3:0] RESET_SYMS = {4'd3, 4'd2, 4'd1, 4'd0};

    function automatic logic [3:0] map_symbol(input logic [3:0] nibble,
                                              input logic [4:0] num_symbols);
        logic [4:0] wide;
        wide = {1'b0, nibble};
        if (wide >= num_symbols) wide = wide - num_symbols;
        return wide[3:0];
    endfunction

endpackage

// File: rtl/slot_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock and reloads SEED on reset.
module slot_lfsr16
    import slot_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) value <= SEED;
        else      value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
    end

endmodule

// File: rtl/slot_reels.sv
// Four-reel spin engine: reels roll from the LFSR on each tick and lock left to
// right; a one-cycle result_valid accompanies the registered jackpot flag.
module slot_reels
    import slot_pkg::*;
#(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          TICK_DIV      = 2_500_000,
    parameter int          SPIN_TICKS    = 40,
    parameter int          STAGGER_TICKS = 10,
    parameter int          NUM_SYMBOLS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spin,
    output logic [3:0] randNum1,
    output logic [3:0] randNum2,
    output logic [3:0] randNum3,
    output logic [3:0] randNum4,
    output logic       spinning,
    output logic       result_valid,
    output logic       jackpot
);

    localparam int LAST_TICK = SPIN_TICKS + 3 * STAGGER_TICKS;
    localparam int DIV_W     = $clog2(TICK_DIV);
    localparam int TICK_W    = $clog2(LAST_TICK + 1);

    state_t            state, state_next;
    logic [15:0]       lfsr;
    logic              spin_d;
    logic              start;
    logic              tick;
    logic              last_lock;
    logic [DIV_W-1:0]  div_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_next;
    logic [3:0]        locked;
    logic [3:0]        lock_now;
    logic [3:0][3:0]   sym;
    logic [3:0][3:0]   sym_next;

    slot_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    assign start     = spin & ~spin_d;
    assign tick      = (state == SPIN) && (div_cnt == DIV_W'(TICK_DIV - 1));
    assign tick_next = tick_cnt + TICK_W'(1);
    assign last_lock = tick && (tick_next == TICK_W'(LAST_TICK));

    // A reel takes the update on its own lock tick, so lock_now only gates later ticks.
    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        sym_next = sym;
        lock_now = '0;
        for (int k = 0; k < 4; k++) begin
            lock_now[k] = tick && (tick_next == TICK_W'(SPIN_TICKS + k * STAGGER_TICKS));
            if (tick && !locked[k]) sym_next[k] = map_symbol(lfsr[4*k +: 4], 5'(NUM_SYMBOLS));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next   = state;
        spinning     = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: if (start) state_next = SPIN;
            SPIN: begin
                spinning = 1'b1;
                if (last_lock) state_next = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spin_d   <= 1'b0;
            div_cnt  <= '0;
            tick_cnt <= '0;
            locked   <= '0;
            sym      <= RESET_SYMS;
            jackpot  <= 1'b0;
        end else begin
            spin_d <= spin;
            if (state == IDLE && start) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                locked   <= '0;
                jackpot  <= 1'b0;
            end else if (state == SPIN) begin
                sym <= sym_next;
                if (tick) begin
                    div_cnt  <= '0;
                    tick_cnt <= tick_next;
                    locked   <= locked | lock_now;
                    if (last_lock)
                        jackpot <= (sym_next[0] == sym_next[1]) &&
                                   (sym_next[1] == sym_next[2]) &&
                                   (sym_next[2] == sym_next[3]);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign randNum1 = sym[0];
    assign randNum2 = sym[1];
    assign randNum3 = sym[2];
    assign randNum4 = sym[3];

endmodule

// File: tb/tb_slot_reels.sv
// Self-checking bench for slot_reels: per-cycle scoreboard of reels and flags
// against a reference built from LFSR values captured at tick times.
module tb_slot_reels;

    localparam int          TICK_DIV      = 4;
    localparam int          SPIN_TICKS    = 3;
    localparam int          STAGGER_TICKS = 2;
    localparam int          NUM_SYMBOLS   = 10;
    localparam logic [15:0] SEED          = 16'hACE1;
    localparam int          LAST_EDGE     = (SPIN_TICKS + 3 * STAGGER_TICKS) * TICK_DIV;
    localparam logic [15:0] RESET_VIEW    = 16'h3210;

    logic       clk = 1'b0;
    logic       rst;
    logic       spin;
    logic [3:0] randNum1, randNum2, randNum3, randNum4;
    logic       spinning, result_valid, jackpot;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] model_lfsr;
    logic [15:0] prev_syms;

    slot_reels #(
        .SEED          (SEED),
        .TICK_DIV      (TICK_DIV),
        .SPIN_TICKS    (SPIN_TICKS),
        .STAGGER_TICKS (STAGGER_TICKS),
        .NUM_SYMBOLS   (NUM_SYMBOLS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spin         (spin),
        .randNum1     (randNum1),
        .randNum2     (randNum2),
        .randNum3     (randNum3),
        .randNum4     (randNum4),
        .spinning     (spinning),
        .result_valid (result_valid),
        .jackpot      (jackpot)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    function automatic logic [3:0] ref_sym(input logic [15:0] v, input int k);
        int nib;
        nib = int'((v >> (4 * k)) & 16'h000F);
        if (nib >= NUM_SYMBOLS) nib = nib - NUM_SYMBOLS;
        return 4'(nib);
    endfunction

    function automatic int lock_tick(input int k);
        return SPIN_TICKS + k * STAGGER_TICKS;
    endfunction

    // h0 is the LFSR value present at the entry edge.
    function automatic bit predict_jackpot(input logic [15:0] h0);
        logic [3:0] s [4];
        for (int k = 0; k < 4; k++) s[k] = ref_sym(lfsr_adv(h0, lock_tick(k) * TICK_DIV), k);
        return (s[0] == s[1]) && (s[1] == s[2]) && (s[2] == s[3]);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) model_lfsr <= SEED;
        else      model_lfsr <= lfsr_step(model_lfsr);
    end

    // Called right after a negedge with spin low. Edge 0 is the entry edge.
    task automatic run_spin(input int mode, input int n_edges, input string name,
                            output logic jp_at_valid, output int rv_count);
        logic [15:0] hist [0:127];
        logic [15:0] exp_syms, obs_syms;
        logic        exp_jp;
        int          a, j, t;
        rv_count    = 0;
        jp_at_valid = 1'b0;
        exp_syms    = prev_syms;
        checks++;
        if (spinning !== 1'b0) $display("FAIL %s idle_before: spinning=%b required 0", name, spinning);
        else passes++;
        hist[0] = model_lfsr;
        spin    = 1'b1;
        for (int e = 1; e <= n_edges; e++) begin
            @(negedge clk);
            a = e - 1;
            j = a / TICK_DIV;
            for (int k = 0; k < 4; k++) begin
                t = (j < lock_tick(k)) ? j : lock_tick(k);
                exp_syms[4*k +: 4] = (t == 0) ? prev_syms[4*k +: 4] : ref_sym(hist[t * TICK_DIV], k);
            end
            exp_jp   = (a >= LAST_EDGE) && (exp_syms[3:0] == exp_syms[7:4]) &&
                       (exp_syms[7:4] == exp_syms[11:8]) && (exp_syms[11:8] == exp_syms[15:12]);
            obs_syms = {randNum4, randNum3, randNum2, randNum1};
            checks++;
            if (obs_syms !== exp_syms)
                $display("FAIL %s syms edge %0d: got %h required %h", name, a, obs_syms, exp_syms);
            else passes++;
            checks++;
            if (spinning !== (a < LAST_EDGE))
                $display("FAIL %s spinning edge %0d: got %b required %b", name, a, spinning, a < LAST_EDGE);
            else passes++;
            checks++;
            if (result_valid !== (a == LAST_EDGE))
                $display("FAIL %s result_valid edge %0d: got %b required %b", name, a, result_valid, a == LAST_EDGE);
            else passes++;
            checks++;
            if (jackpot !== exp_jp)
                $display("FAIL %s jackpot edge %0d: got %b required %b", name, a, jackpot, exp_jp);
            else passes++;
            if (result_valid === 1'b1) begin
                rv_count++;
                jp_at_valid = jackpot;
                checks++;
                if (randNum1 >= 4'd10 || randNum2 >= 4'd10 || randNum3 >= 4'd10 || randNum4 >= 4'd10)
                    $display("FAIL %s sym_range: got %h required all digits < 10", name, obs_syms);
                else passes++;
            end
            hist[e] = model_lfsr;
            case (mode)
                1:       spin = (e < 100);
                2:       spin = (e == 10) || (e == 37);
                default: spin = 1'b0;
            endcase
        end
        prev_syms = exp_syms;
    endtask

    task automatic check_rv_count(input string name, input int got);
        checks++;
        if (got !== 1) $display("FAIL %s rv_count: got %0d required 1", name, got);
        else passes++;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({randNum4, randNum3, randNum2, randNum1} !== RESET_VIEW)
            $display("FAIL %s reset_syms: got %h required %h", name,
                     {randNum4, randNum3, randNum2, randNum1}, RESET_VIEW);
        else passes++;
        checks++;
        if ({spinning, result_valid, jackpot} !== 3'b000)
            $display("FAIL %s reset_flags: got %b required 000", name, {spinning, result_valid, jackpot});
        else passes++;
        checks++;
        if (dut.lfsr !== SEED) $display("FAIL %s reset_lfsr: got %h required %h", name, dut.lfsr, SEED);
        else passes++;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        spin = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst       = 1'b1;
        prev_syms = RESET_VIEW;
        repeat (5) @(negedge clk);
        checks++;
        if (dut.lfsr !== model_lfsr) $display("FAIL lfsr_sequence: got %h required %h", dut.lfsr, model_lfsr);
        else passes++;
    endtask

    task automatic test_basic_spin();
        logic jp;
        int   rvc;
        run_spin(0, 40, "basic", jp, rvc);
        check_rv_count("basic", rvc);
    endtask

    task automatic test_hold();
        logic jp;
        int   rvc;
        repeat (3) @(negedge clk);
        run_spin(1, 110, "hold", jp, rvc);
        check_rv_count("hold", rvc);
    endtask

    task automatic test_repulse();
        logic jp;
        int   rvc;
        repeat (2) @(negedge clk);
        run_spin(2, 50, "repulse", jp, rvc);
        check_rv_count("repulse", rvc);
    endtask

    task automatic test_random_sweep();
        logic jp;
        int   rvc;
        for (int s = 0; s < 8; s++) begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
            run_spin(0, 40, "sweep", jp, rvc);
            check_rv_count("sweep", rvc);
        end
    endtask

    task automatic test_jackpot();
        logic [15:0] h;
        int          d;
        bit          found;
        logic        jp;
        int          rvc;
        h     = model_lfsr;
        found = 1'b0;
        d     = 0;
        for (int i = 0; i < 40000 && !found; i++) begin
            if (predict_jackpot(h)) begin
                found = 1'b1;
                d     = i;
            end else begin
                h = lfsr_step(h);
            end
        end
        checks++;
        if (!found) begin
            $display("FAIL jackpot_search: got no jackpot start within 40000 cycles required one");
        end else begin
            repeat (d) @(negedge clk);
            run_spin(0, 40, "jackpot", jp, rvc);
            if (jp !== 1'b1) $display("FAIL jackpot_flag: got %b required 1", jp);
            else passes++;
            repeat (4) @(negedge clk);
            run_spin(0, 40, "jackpot_clear", jp, rvc);
            check_rv_count("jackpot_clear", rvc);
        end
    endtask

    task automatic test_reset_mid_spin();
        int highs;
        repeat (2) @(negedge clk);
        spin = 1'b1;
        @(negedge clk);
        spin = 1'b0;
        repeat (TICK_DIV * 5) @(negedge clk);
        checks++;
        if (spinning !== 1'b1) $display("FAIL midspin_active: spinning=%b required 1", spinning);
        else passes++;
        rst = 1'b0;
        #1;
        check_reset_outputs("midspin");
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        prev_syms = RESET_VIEW;
        highs     = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1 || spinning === 1'b1) highs++;
        end
        checks++;
        if (highs !== 0) $display("FAIL midspin_quiet: got %0d active cycles required 0", highs);
        else passes++;
        checks++;
        if ({randNum4, randNum3, randNum2, randNum1} !== RESET_VIEW)
            $display("FAIL midspin_hold: got %h required %h", {randNum4, randNum3, randNum2, randNum1}, RESET_VIEW);
        else passes++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_spin();
        test_hold();
        test_repulse();
        test_random_sweep();
        test_jackpot();
        test_reset_mid_spin();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
